alu_acc_seq: RTL and testbench

Parametrised, registered successor to the team's combinational 8-bit add/subtract ALU. Adds an accumulator register, logic ops, status flags and a `valid`/`ready` request handshake. An optional multi-cycle shift-add multiplier is selected by a macro. It sits between the datapath register file and the result bus, and returns one registered result per accepted request.

---
 rtl/alu_acc_seq.sv | 151 +++++++++++++++
 tb/tb_alu_acc_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_acc_seq.sv
// Registered add/sub/logic ALU with accumulator, status flags and valid/ready request handshake.
// Optional shift-add multiplier (op 111) is built only when ALU_ACC_SEQ_MUL_EN is defined.
module alu_acc_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  input  logic             E,
  output logic [WIDTH-1:0] W,
  output logic             out_valid,
  output logic [WIDTH-1:0] acc,
  output logic             carry,
  output logic             zero,
  output logic             ovf
);

  typedef enum logic [2:0] {
    OP_ADD     = 3'b000,
    OP_SUB     = 3'b001,
    OP_AND     = 3'b010,
    OP_OR      = 3'b011,
    OP_XOR     = 3'b100,
    OP_ACC_ADD = 3'b101,
    OP_ACC_CLR = 3'b110,
    OP_MUL     = 3'b111
  } op_e;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state;
  op_e              opc;
  logic [WIDTH:0]   sum_ab, diff_ab, sum_acc;
  logic [WIDTH-1:0] res, acc_nxt;
  logic             res_c, res_v;

  assign opc      = op_e'(op);
  assign in_ready = (state == IDLE);
  assign sum_ab   = {1'b0, A} + {1'b0, B};
  assign diff_ab  = {1'b0, A} - {1'b0, B};
  assign sum_acc  = {1'b0, acc} + {1'b0, A};

  // Single-cycle result; E=0 and the multiplier-less op 111 fall through to zeros.
  always_comb begin
    res     = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    acc_nxt = acc;
    if (E) begin
      case (opc)
        OP_ADD: begin
          res   = sum_ab[WIDTH-1:0];
          res_c = sum_ab[WIDTH];
          res_v = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ab[WIDTH-1] != A[WIDTH-1]);
        end
        OP_SUB: begin
          res   = diff_ab[WIDTH-1:0];
          res_c = diff_ab[WIDTH];
          res_v = (A[WIDTH-1] != B[WIDTH-1]) && (diff_ab[WIDTH-1] != A[WIDTH-1]);
        end
        OP_AND: res = A & B;
        OP_OR:  res = A | B;
        OP_XOR: res = A ^ B;
        OP_ACC_ADD: begin
          acc_nxt = sum_acc[WIDTH-1:0];
          res     = sum_acc[WIDTH-1:0];
          res_c   = sum_acc[WIDTH];
          res_v   = (acc[WIDTH-1] == A[WIDTH-1]) && (sum_acc[WIDTH-1] != acc[WIDTH-1]);
        end
        OP_ACC_CLR: acc_nxt = '0;
        default: ;
      endcase
    end
  end

`ifdef ALU_ACC_SEQ_MUL_EN
  localparam int unsigned CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] prod, prod_nxt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH:0]     step;
  logic [CW-1:0]      cnt;

  // Right-shifting product: the low half starts as the multiplier and is consumed LSB-first.
  always_comb begin
    step     = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_nxt = {step, prod[WIDTH-1:1]};
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      W         <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
`ifdef ALU_ACC_SEQ_MUL_EN
      prod      <= '0;
      mcand     <= '0;
      cnt       <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
`ifdef ALU_ACC_SEQ_MUL_EN
            if (E && opc == OP_MUL) begin
              state <= BUSY;
              prod  <= {{WIDTH{1'b0}}, B};
              mcand <= A;
              cnt   <= '0;
            end else
`endif
            begin
              W         <= res;
              carry     <= res_c;
              ovf       <= res_v;
              zero      <= (res == '0);
              acc       <= acc_nxt;
              out_valid <= 1'b1;
            end
          end
        end
`ifdef ALU_ACC_SEQ_MUL_EN
        BUSY: begin
          prod <= prod_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= IDLE;
            W         <= prod_nxt[WIDTH-1:0];
            carry     <= |prod_nxt[2*WIDTH-1:WIDTH];
            ovf       <= 1'b0;
            zero      <= (prod_nxt[WIDTH-1:0] == '0);
            out_valid <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_acc_seq.sv
// Scoreboard bench for alu_acc_seq: driver pushes model results, monitor checks every cycle.
module tb_alu_acc_seq;
  localparam int unsigned WIDTH = 8;
  localparam longint FULL = longint'(1) << WIDTH;
  localparam longint MASK = FULL - 1;
  localparam longint HALF = FULL / 2;
`ifdef ALU_ACC_SEQ_MUL_EN
  localparam bit MULEN = 1'b1;
`else
  localparam bit MULEN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic [2:0]       op = '0;
  logic             E = 1'b0;
  logic [WIDTH-1:0] W;
  logic             out_valid;
  logic [WIDTH-1:0] acc;
  logic             carry, zero, ovf;

  always #5 clk = ~clk;

  alu_acc_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .op(op), .E(E), .W(W), .out_valid(out_valid),
    .acc(acc), .carry(carry), .zero(zero), .ovf(ovf)
  );

  typedef struct {
    longint w;
    bit     c;
    bit     v;
    longint a;
    int     acc_edge;
    int     due;
  } exp_t;

  exp_t   q[$];
  exp_t   cur;
  longint m_acc = 0;
  int     cyc = 0;
  int     passes = 0;
  int     total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, cyc);
  endtask

  function automatic longint sg(input longint x);
    return (x >= HALF) ? x - FULL : x;
  endfunction

  function automatic bit sovf(input longint s);
    return (s > HALF - 1) || (s < -HALF);
  endfunction

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic issue(input int o, input longint a, input longint b, input bit e);
    exp_t   x;
    longint s;
    int     k = 0;
    while (!in_ready && k < 4 * WIDTH) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      chk("ready_timeout", longint'(in_ready), 1);
      return;
    end
    x.w = 0; x.c = 0; x.v = 0;
    if (e) begin
      case (o)
        0: begin s = a + b; x.w = s & MASK; x.c = (s >> WIDTH) != 0; x.v = sovf(sg(a) + sg(b)); end
        1: begin x.w = (a - b) & MASK; x.c = a < b; x.v = sovf(sg(a) - sg(b)); end
        2: x.w = a & b;
        3: x.w = a | b;
        4: x.w = a ^ b;
        5: begin
          s = m_acc + a;
          x.v = sovf(sg(m_acc) + sg(a));
          x.c = (s >> WIDTH) != 0;
          m_acc = s & MASK;
          x.w = m_acc;
        end
        6: m_acc = 0;
        default: if (MULEN) begin s = a * b; x.w = s & MASK; x.c = (s >> WIDTH) != 0; end
      endcase
    end
    x.a = m_acc;
    x.acc_edge = cyc + 1;
    x.due = x.acc_edge + ((o == 7 && e && MULEN) ? int'(WIDTH) : 0);
    A = a[WIDTH-1:0];
    B = b[WIDTH-1:0];
    op = o[2:0];
    E = e;
    in_valid = 1'b1;
    q.push_back(x);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    q.delete();
    m_acc = 0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: compares handshake and held outputs every cycle against the scoreboard.
  initial begin
    bit ev, busy;
    cur.w = 0; cur.c = 0; cur.v = 0; cur.a = 0; cur.acc_edge = 0; cur.due = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        cur.w = 0; cur.c = 0; cur.v = 0; cur.a = 0;
        ev = 1'b0;
        busy = 1'b0;
      end else begin
        ev   = (q.size() > 0) && (q[0].due == cyc);
        busy = (q.size() > 0) && (q[0].acc_edge <= cyc) && (q[0].due > cyc);
      end
      chk("out_valid", longint'(out_valid), longint'(ev));
      chk("in_ready", longint'(in_ready), longint'(!busy));
      if (ev) cur = q.pop_front();
      chk("W", longint'(W), cur.w);
      chk("carry", longint'(carry), longint'(cur.c));
      chk("zero", longint'(zero), longint'(cur.w == 0));
      chk("ovf", longint'(ovf), longint'(cur.v));
      chk("acc", longint'(acc), cur.a);
    end
  end

  initial begin
    int k;
    @(negedge clk);
    do_reset(3);

    issue(0, 200, 100, 1);
    issue(1, 5, 7, 1);
    issue(0, 100, 100, 1);
    issue(0, 3, 4, 0);
    issue(6, 0, 0, 1);
    issue(5, 250, 0, 1);
    issue(5, 10, 0, 1);
    issue(1, 128, 1, 1);
    issue(0, 255, 1, 1);

    issue(7, 15, 17, 1);
    issue(7, 16, 16, 1);
    if (MULEN) begin
      repeat (4) begin
        A = WIDTH'($urandom);
        B = WIDTH'($urandom);
        op = 3'b000;
        E = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
      end
      in_valid = 1'b0;
    end
    issue(7, 255, 255, 1);
    issue(7, 3, 3, 1);
    issue(7, 9, 9, 0);
    issue(2, 8'hF0, 8'h3C, 1);
    issue(3, 8'hF0, 8'h0F, 1);
    issue(4, 8'hAA, 8'hAA, 1);

    issue(5, 77, 0, 1);
    issue(7, 15, 17, 1);
    repeat (3) @(negedge clk);
    do_reset(1);

    for (int n = 0; n < 300; n++) begin
      issue(int'($urandom_range(0, 7)), longint'($urandom) & MASK, longint'($urandom) & MASK,
            $urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    k = 0;
    while (q.size() > 0 && k < 4 * int'(WIDTH)) begin
      @(negedge clk);
      k++;
    end
    chk("drain", longint'(q.size()), 0);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
